capture_ctrl: RTL

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_pkg.sv | 15 +
 rtl/cap_ptr.sv | 35 +++
 rtl/capture_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared constants and state type for the capture controller
package capture_pkg;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/cap_ptr.sv
// rtl/cap_ptr.sv - wrapping sample RAM write pointer with enable and synchronous clear
module cap_ptr #(
  parameter int ADDR_W = capture_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // Clear wins over advance; the power-of-two width gives the wrap for free.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - pre/post-trigger capture sequencer for a circular sample RAM
module capture_ctrl #(
  parameter int DEPTH  = capture_pkg::DEPTH,
  parameter int ADDR_W = capture_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              wrt_smpl,
  input  logic              triggered,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              clr_cap_done,
  input  logic              abort,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              armed,
  output logic              capture_done,
  output logic [ADDR_W-1:0] end_addr
);

  import capture_pkg::*;

  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  cap_state_t        state_q, state_d;
  logic [CNT_W-1:0]  smpl_cnt_q, smpl_cnt_d;
  logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;

  logic              ptr_clr;
  logic              active;
  logic [ADDR_W-1:0] waddr_nxt;
  logic [CNT_W-1:0]  trig_pos_w;
  logic [CNT_W-1:0]  pre_target;
  logic [CNT_W-1:0]  smpl_inc;
  logic [CNT_W-1:0]  post_inc;

  // Pre-trigger fill length is whatever part of the RAM the post-trigger samples do not claim.
  assign trig_pos_w = {1'b0, trig_pos};
  assign pre_target = DEPTH_C - trig_pos_w;
  assign smpl_inc   = smpl_cnt_q + ONE_C;
  assign post_inc   = post_cnt_q + ONE_C;

  // Writes pass straight through while capturing; abort suppresses the cycle's write.
  assign active    = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
  assign we        = wrt_smpl && active && !abort;
  assign waddr_nxt = waddr + {{(ADDR_W-1){1'b0}}, we};

  cap_ptr #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (we),
    .clr_i (ptr_clr),
    .ptr_o (waddr)
  );

  // Next-state, counter and pointer-clear decode; abort overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    smpl_cnt_d = smpl_cnt_q;
    post_cnt_d = post_cnt_q;
    ptr_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        ptr_clr    = 1'b1;
        smpl_cnt_d = '0;
        post_cnt_d = '0;
        if (run) begin
          state_d = PRE;
        end
      end
      PRE: begin
        if (we) begin
          smpl_cnt_d = smpl_inc;
          if (smpl_inc == pre_target) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        // A write coinciding with the trigger is the trigger sample itself, not a post sample.
        if (triggered) begin
          state_d = (trig_pos_w == '0) ? DONE : POST;
        end
      end
      POST: begin
        if (we) begin
          post_cnt_d = post_inc;
          if (post_inc == trig_pos_w) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (clr_cap_done) begin
          state_d = IDLE;
          ptr_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_clr = 1'b1;
      end
    endcase

    if (abort) begin
      state_d    = IDLE;
      smpl_cnt_d = '0;
      post_cnt_d = '0;
      ptr_clr    = 1'b1;
    end
  end

  // Registered status outputs follow the next state; end_addr latches the post-write pointer on DONE entry.
  always_comb begin
    armed_d    = (state_d == ARMED);
    done_d     = (state_d == DONE);
    end_addr_d = end_addr_q;
    if ((state_d == DONE) && (state_q != DONE)) begin
      end_addr_d = waddr_nxt;
    end
    if (abort) begin
      end_addr_d = '0;
    end
  end

  // State, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      smpl_cnt_q <= '0;
      post_cnt_q <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      end_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      smpl_cnt_q <= smpl_cnt_d;
      post_cnt_q <= post_cnt_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      end_addr_q <= end_addr_d;
    end
  end

  assign armed        = armed_q;
  assign capture_done = done_q;
  assign end_addr     = end_addr_q;

endmodule
